adder_arb: RTL and testbench



---
 rtl/adder_arb_pkg.sv | 18 +
 rtl/adder.sv | 30 +++
 rtl/adder_arb_rr_arbiter.sv | 34 +++
 rtl/csa32.sv | 36 +++
 rtl/adder_arb.sv | 148 ++++++++++++++
 tb/tb_adder_arb.sv | 254 +++++++++++++++++++++++++
 6 files changed

// File: rtl/adder_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_arb_pkg: shared types and widths for the adder arbiter slice    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package adder_arb_pkg;

  localparam int ADD_W = 32;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder: reference ripple-carry adder                                   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] w_c;

  assign w_c[0] = cin;

  generate
    for (genvar g = 0; g < W; g++) begin : g_fa
      assign sum[g]   = a[g] ^ b[g] ^ w_c[g];
      assign w_c[g+1] = (a[g] & b[g]) | (w_c[g] & (a[g] ^ b[g]));
    end
  endgenerate

  assign cout = w_c[W];

endmodule
`default_nettype wire

// File: rtl/adder_arb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin grant, search from last_grant+1 |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [N_REQ-1:0]         grant
);

  localparam int IDX_W = $clog2(N_REQ);

  int   w_idx;
  logic w_found;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = int'(last_grant) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && req[w_idx[IDX_W-1:0]]) begin
        grant[w_idx[IDX_W-1:0]] = 1'b1;
        w_found                 = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/csa32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | csa32: 32-bit carry-select adder, 4-bit blocks                        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module csa32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  localparam int BLK  = 4;
  localparam int NBLK = 32 / BLK;

  logic [NBLK:0] w_c;

  assign w_c[0] = cin;

  generate
    for (genvar g = 0; g < NBLK; g++) begin : g_blk
      logic [BLK:0] w_s0;
      logic [BLK:0] w_s1;
      // Both carry-in cases are precomputed; the incoming carry only selects.
      assign w_s0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
      assign w_s1 = w_s0 + {{BLK{1'b0}}, 1'b1};
      assign sum[g*BLK +: BLK] = w_c[g] ? w_s1[BLK-1:0] : w_s0[BLK-1:0];
      assign w_c[g+1]          = w_c[g] ? w_s1[BLK]     : w_s0[BLK];
    end
  endgenerate

  assign cout = w_c[NBLK];

endmodule
`default_nettype wire

// File: rtl/adder_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_arb: round-robin sharing of one csa32 between N_REQ requesters. |
// | Optional ADDER_ARB_CHECK_EN adds a ripple reference and sticky check. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module adder_arb
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*ADD_W-1:0] req_a,
  input  logic [N_REQ*ADD_W-1:0] req_b,
  input  logic [N_REQ-1:0]       req_cin,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [ADD_W-1:0]       rsp_sum,
  output logic                   rsp_cout,
  output logic [CNT_W-1:0]       op_cnt,
  output logic                   chk_err
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_owner, r_last_grant, w_win_idx;
  logic [ADD_W-1:0] r_a, r_b, r_sum, w_sum, w_win_a, w_win_b;
  logic             r_cin, r_cout, w_cout, w_win_cin;
  logic [CNT_W-1:0] r_op_cnt;
  logic [N_REQ-1:0] w_grant;
  logic             w_req_fire, w_rsp_fire;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req_valid),
    .last_grant(r_last_grant),
    .grant     (w_grant)
  );

  csa32 u_csa (
    .a   (r_a),
    .b   (r_b),
    .cin (r_cin),
    .sum (w_sum),
    .cout(w_cout)
  );

  // One-hot grant to index plus operand select.
  always_comb begin
    w_win_idx = '0;
    w_win_a   = '0;
    w_win_b   = '0;
    w_win_cin = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_win_idx = IDX_W'(i);
        w_win_a   = req_a[i*ADD_W +: ADD_W];
        w_win_b   = req_b[i*ADD_W +: ADD_W];
        w_win_cin = req_cin[i];
      end
    end
  end

  assign w_req_fire = (r_state == IDLE) && (|w_grant);
  assign w_rsp_fire = (r_state == RESP) && rsp_ready[r_owner];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req_fire) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (w_rsp_fire) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (r_state == IDLE) req_ready = w_grant;
    if (r_state == RESP) rsp_valid[r_owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= IDX_W'(N_REQ - 1);
      r_owner      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_cin        <= 1'b0;
      r_sum        <= '0;
      r_cout       <= 1'b0;
      r_op_cnt     <= '0;
    end else begin
      if (w_req_fire) begin
        r_a          <= w_win_a;
        r_b          <= w_win_b;
        r_cin        <= w_win_cin;
        r_owner      <= w_win_idx;
        r_last_grant <= w_win_idx;
      end
      if (r_state == EXEC) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
      end
      if (w_rsp_fire) r_op_cnt <= r_op_cnt + CNT_W'(1);
    end
  end

  assign rsp_sum  = r_sum;
  assign rsp_cout = r_cout;
  assign op_cnt   = r_op_cnt;

`ifdef ADDER_ARB_CHECK_EN
  logic [ADD_W-1:0] w_ref_sum;
  logic             w_ref_cout;
  logic             r_chk_err;

  adder #(.W(ADD_W)) u_ref (
    .a   (r_a),
    .b   (r_b),
    .cin (r_cin),
    .sum (w_ref_sum),
    .cout(w_ref_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_chk_err <= 1'b0;
    else if ((r_state == EXEC) && ({w_ref_cout, w_ref_sum} != {w_cout, w_sum}))
      r_chk_err <= 1'b1;
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adder_arb: directed scoreboard bench for adder_arb                 |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_adder_arb;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_ready, req_cin, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_a, req_b;
  logic [31:0]   rsp_sum;
  logic          rsp_cout;
  logic [15:0]   op_cnt;
  logic          chk_err;

  typedef struct {
    int          owner;
    logic [32:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_rsp    = 0;

  always #5 clk = ~clk;

  adder_arb #(.N_REQ(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_cin  (req_cin),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sum  (rsp_sum),
    .rsp_cout (rsp_cout),
    .op_cnt   (op_cnt),
    .chk_err  (chk_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      check("req_ready_onehot", 64'($countones(req_ready) > 1), 64'd0);
      if ((rsp_valid & rsp_ready) != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_owner", 64'(rsp_valid), 64'(1 << e.owner));
          check("rsp_result", 64'({rsp_cout, rsp_sum}), 64'(e.res));
        end
        n_rsp++;
      end
    end
  end

  task automatic wait_accept(input int i);
    bit got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) got = 1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: req %0d never accepted", i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [32:0] exp, input bit push);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_cin[i]        = cin;
    req_valid[i]      = 1'b1;
    if (push) exp_q.push_back('{owner: i, res: exp});
    wait_accept(i);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input bit rnd);
    int k = 0;
    while (n_rsp < target && k < 100) begin
      @(posedge clk);
      #1;
      k++;
      if (rnd) rsp_ready = 4'($urandom);
    end
    if (n_rsp < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got %0d responses, expected %0d", n_rsp, target);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic cin);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_cin[i]        = cin;
    req_valid[i]      = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [31:0] ra, rb;
    logic        rc;
    int          ri;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_sum",   64'(rsp_sum),   64'd0);
    check("rst_rsp_cout",  64'(rsp_cout),  64'd0);
    check("rst_op_cnt",    64'(op_cnt),    64'd0);
    check("rst_chk_err",   64'(chk_err),   64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // First request from req 1: 1 + FFFFFFFF = 1_00000000
    rsp_ready = '1;
    do_op(1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 33'h1_0000_0000, 1'b1);
    @(negedge clk);
    check("exec_no_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("rsp_valid_latency", 64'(rsp_valid), 64'b0010);
    @(posedge clk);
    #1;
    check("op_cnt_first", 64'(op_cnt), 64'd1);

    // Fairness from a fresh reset: 0,1,2,3,0,1
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = n_rsp;
    exp_q.push_back('{owner: 0, res: 33'h0_0000_0030});
    exp_q.push_back('{owner: 1, res: 33'h1_FFFF_FFFF});
    exp_q.push_back('{owner: 2, res: 33'h1_0000_0000});
    exp_q.push_back('{owner: 3, res: 33'h0_2345_678A});
    exp_q.push_back('{owner: 0, res: 33'h0_0000_0030});
    exp_q.push_back('{owner: 1, res: 33'h1_FFFF_FFFF});
    set_req(0, 32'h0000_0010, 32'h0000_0020, 1'b0);
    set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    set_req(2, 32'h8000_0000, 32'h8000_0000, 1'b0);
    set_req(3, 32'h1234_5678, 32'h1111_1111, 1'b1);
    wait_rsp(base + 6, 1'b0);
    req_valid = '0;
    check("op_cnt_fair", 64'(op_cnt), 64'd6);

    // Backpressure on req 2 while req 0 waits; non-owner ready bits high
    base = n_rsp;
    rsp_ready = 4'b1011;
    do_op(2, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 33'h0_8000_0000, 1'b1);
    set_req(0, 32'h0000_0005, 32'h0000_0006, 1'b0);
    exp_q.push_back('{owner: 0, res: 33'h0_0000_000B});
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'b0100);
      check("bp_rsp_sum",   64'(rsp_sum),   64'h8000_0000);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1 rsp_ready = '1;
    wait_accept(0);
    req_valid[0] = 1'b0;
    wait_rsp(base + 2, 1'b0);
    check("op_cnt_bp", 64'(op_cnt), 64'd8);

    // Reset while in EXEC: operation dropped, then req 0 wins over req 3
    do_op(3, 32'h0000_0001, 32'h0000_0002, 1'b0, 33'h0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rstx_no_valid", 64'(rsp_valid), 64'd0);
    end
    check("rstx_op_cnt", 64'(op_cnt), 64'd0);
    @(posedge clk);
    #1;
    base = n_rsp;
    exp_q.push_back('{owner: 0, res: 33'h1_0000_0000});
    exp_q.push_back('{owner: 3, res: 33'h0_0000_0003});
    set_req(0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    set_req(3, 32'h0000_0001, 32'h0000_0002, 1'b0);
    wait_rsp(base + 2, 1'b0);
    req_valid = '0;
    check("op_cnt_after_rstx", 64'(op_cnt), 64'd2);

    // Counter wrap
    force dut.r_op_cnt = 16'hFFFE;
    #1 release dut.r_op_cnt;
    base = n_rsp;
    do_op(1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100, 1'b1);
    wait_rsp(base + 1, 1'b0);
    check("op_cnt_ffff", 64'(op_cnt), 64'hFFFF);
    do_op(2, 32'hFFFF_0000, 32'h0001_0000, 1'b1, 33'h1_0000_0001, 1'b1);
    wait_rsp(base + 2, 1'b0);
    check("op_cnt_wrap", 64'(op_cnt), 64'h0000);

    // Random operands, requesters and response backpressure
    for (int r = 0; r < 200; r++) begin
      ri = int'($urandom_range(0, N - 1));
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      base = n_rsp;
      rsp_ready = 4'($urandom);
      do_op(ri, ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {32'd0, rc}, 1'b1);
      wait_rsp(base + 1, 1'b1);
    end

    check("chk_err_final", 64'(chk_err), 64'd0);
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
